// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM result, waits for load data,
// aligns/extends it and drives the register file write port.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem,
  input  logic [RD_WIDTH-1:0]   mem_rd,
  input  logic                  mem_rd_we,
  input  logic                  mem_is_load,
  input  logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [DATA_WIDTH-1:0] mem_pc,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  allow_in_regfile,
  output logic                  allow_in_wb,
  output logic                  valid_wb,
  output logic                  ready_go_wb,
  output logic                  rf_we,
  output logic [RD_WIDTH-1:0]   rf_wa,
  output logic [DATA_WIDTH-1:0] rf_wd,
  output logic [DATA_WIDTH-1:0] wb_pc,
  output logic [CNT_WIDTH-1:0]  instret
);

  typedef enum logic {
    S_WAIT_RSP = 1'b0,
    S_DONE     = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_valid;
  logic [RD_WIDTH-1:0]   r_rd;
  logic                  r_rd_we;
  logic                  r_is_load;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rsp_buf;
  logic [CNT_WIDTH-1:0]  r_instret;

  logic                  w_rsp_held;
  logic                  w_ready;
  logic                  w_retire;
  logic                  w_accept;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_ld_raw;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ld_data;

  assign w_rsp_held = (r_state == S_DONE);
  assign w_ready    = ~r_is_load | w_rsp_held | dmem_rvalid;
  assign w_retire   = r_valid & w_ready & allow_in_regfile;
  assign w_accept   = valid_mem & (~r_valid | w_retire);
  // Only buffer a response that cannot be consumed this cycle.
  assign w_capture  = r_valid & r_is_load & ~w_rsp_held
                    & dmem_rvalid & ~w_retire;

  assign w_ld_raw = w_rsp_held ? r_rsp_buf : dmem_rdata;

  always_comb begin
    w_byte = w_ld_raw[7:0];
    case (r_result[1:0])
      2'd1:    w_byte = w_ld_raw[15:8];
      2'd2:    w_byte = w_ld_raw[23:16];
      2'd3:    w_byte = w_ld_raw[31:24];
      default: w_byte = w_ld_raw[7:0];
    endcase
  end

  assign w_half = r_result[1] ? w_ld_raw[31:16] : w_ld_raw[15:0];

  always_comb begin
    w_ld_data = w_ld_raw;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = w_ld_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_WAIT_RSP;
      r_valid   <= 1'b0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_is_load <= 1'b0;
      r_funct3  <= '0;
      r_result  <= '0;
      r_pc      <= '0;
      r_rsp_buf <= '0;
      r_instret <= '0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_rd      <= mem_rd;
        r_rd_we   <= mem_rd_we;
        r_is_load <= mem_is_load;
        r_funct3  <= mem_funct3;
        r_result  <= mem_result;
        r_pc      <= mem_pc;
        r_state   <= S_WAIT_RSP;
      end else if (w_retire) begin
        r_valid <= 1'b0;
        r_state <= S_WAIT_RSP;
      end else if (w_capture) begin
        r_rsp_buf <= dmem_rdata;
        r_state   <= S_DONE;
      end
      if (w_retire)
        r_instret <= r_instret + 1'b1;
    end
  end

  assign allow_in_wb = ~r_valid | w_retire;
  assign valid_wb    = r_valid;
  assign ready_go_wb = w_ready;
  assign rf_we       = r_valid & r_rd_we;
  assign rf_wa       = r_rd;
  assign rf_wd       = r_is_load ? w_ld_data : r_result;
  assign wb_pc       = r_pc;
  assign instret     = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU ops, aligned loads,
// stalled load response, back-to-back flow, reset mid-load.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_mem;
  logic [4:0]  mem_rd;
  logic        mem_rd_we;
  logic        mem_is_load;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_result;
  logic [31:0] mem_pc;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        allow_in_regfile;
  logic        allow_in_wb;
  logic        valid_wb;
  logic        ready_go_wb;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] wb_pc;
  logic [63:0] instret;

  int n_vec = 0;
  int n_bad = 0;

  wb_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_mem        (valid_mem),
    .mem_rd           (mem_rd),
    .mem_rd_we        (mem_rd_we),
    .mem_is_load      (mem_is_load),
    .mem_funct3       (mem_funct3),
    .mem_result       (mem_result),
    .mem_pc           (mem_pc),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .allow_in_regfile (allow_in_regfile),
    .allow_in_wb      (allow_in_wb),
    .valid_wb         (valid_wb),
    .ready_go_wb      (ready_go_wb),
    .rf_we            (rf_we),
    .rf_wa            (rf_wa),
    .rf_wd            (rf_wd),
    .wb_pc            (wb_pc),
    .instret          (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd,
                       input logic ld,
                       input logic [2:0] f3,
                       input logic [31:0] res,
                       input logic [31:0] pc);
    valid_mem   = 1'b1;
    mem_rd      = rd;
    mem_rd_we   = 1'b1;
    mem_is_load = ld;
    mem_funct3  = f3;
    mem_result  = res;
    mem_pc      = pc;
    tick();
    valid_mem = 1'b0;
  endtask

  task automatic do_load(input string tag,
                         input logic [2:0] f3,
                         input logic [31:0] addr,
                         input logic [31:0] data,
                         input logic [31:0] exp);
    issue(5'd6, 1'b1, f3, addr, 32'h200);
    dmem_rvalid = 1'b1;
    dmem_rdata  = data;
    #1;
    chk(tag, {32'd0, rf_wd}, {32'd0, exp});
    tick();
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    valid_mem = 1'b0;
    mem_rd = '0;
    mem_rd_we = 1'b0;
    mem_is_load = 1'b0;
    mem_funct3 = '0;
    mem_result = '0;
    mem_pc = '0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    allow_in_regfile = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_valid", 64'(valid_wb), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_allow", 64'(allow_in_wb), 64'd1);
    chk("rst_instret", instret, 64'd0);

    // ALU op
    issue(5'd5, 1'b0, 3'b000, 32'h1234, 32'h40);
    #1;
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_wa", 64'(rf_wa), 64'd5);
    chk("alu_wd", 64'(rf_wd), 64'h1234);
    chk("alu_rdy", 64'(ready_go_wb), 64'd1);
    chk("alu_pc", 64'(wb_pc), 64'h40);
    chk("alu_cnt0", instret, 64'd0);
    tick();
    chk("alu_cnt1", instret, 64'd1);
    chk("alu_vld", 64'(valid_wb), 64'd0);

    // LW with 3 wait cycles
    issue(5'd7, 1'b1, 3'b010, 32'h100, 32'h44);
    for (int i = 0; i < 3; i++) begin
      chk("lw_rdy0", 64'(ready_go_wb), 64'd0);
      chk("lw_allow0", 64'(allow_in_wb), 64'd0);
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    #1;
    chk("lw_rdy1", 64'(ready_go_wb), 64'd1);
    chk("lw_wd", 64'(rf_wd), 64'hDEADBEEF);
    chk("lw_allow1", 64'(allow_in_wb), 64'd1);
    tick();
    dmem_rvalid = 1'b0;
    chk("lw_cnt", instret, 64'd2);

    // Alignment / extension
    do_load("lb3", 3'b000, 32'h203, 32'h80FF7F01, 32'hFFFFFF80);
    do_load("lbu3", 3'b100, 32'h203, 32'h80FF7F01, 32'h00000080);
    do_load("lb1", 3'b000, 32'h201, 32'h80FF7F01, 32'h0000007F);
    do_load("lh2", 3'b001, 32'h202, 32'h80FF7F01, 32'hFFFF80FF);
    do_load("lh3", 3'b001, 32'h203, 32'h80FF7F01, 32'hFFFF80FF);
    do_load("lhu0", 3'b101, 32'h200, 32'h80FF7F01, 32'h00007F01);
    do_load("lw_off", 3'b010, 32'h203, 32'h80FF7F01, 32'h80FF7F01);
    chk("ld_cnt", instret, 64'd9);

    // Stalled load: response buffered while regfile blocks
    allow_in_regfile = 1'b0;
    issue(5'd8, 1'b1, 3'b010, 32'h300, 32'h48);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hA5A5A5A5;
    #1;
    chk("st_rdy", 64'(ready_go_wb), 64'd1);
    chk("st_allow0", 64'(allow_in_wb), 64'd0);
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h12345678;
    #1;
    chk("st_held", 64'(ready_go_wb), 64'd1);
    chk("st_wd0", 64'(rf_wd), 64'hA5A5A5A5);
    chk("st_pc", 64'(wb_pc), 64'h48);
    tick();
    allow_in_regfile = 1'b1;
    #1;
    chk("st_wd1", 64'(rf_wd), 64'hA5A5A5A5);
    chk("st_allow1", 64'(allow_in_wb), 64'd1);
    chk("st_cnt0", instret, 64'd9);
    tick();
    chk("st_cnt1", instret, 64'd10);

    // Four back-to-back ALU ops
    valid_mem   = 1'b1;
    mem_rd_we   = 1'b1;
    mem_is_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rd     = 5'(10 + i);
      mem_result = 32'h1000 + 32'(i);
      mem_pc     = 32'h80 + 32'(4 * i);
      tick();
      chk("b2b_wa", 64'(rf_wa), 64'(10 + i));
      chk("b2b_wd", 64'(rf_wd), 64'(32'h1000 + 32'(i)));
      chk("b2b_allow", 64'(allow_in_wb), 64'd1);
      chk("b2b_cnt", instret, 64'(10 + i));
    end
    valid_mem = 1'b0;
    tick();
    chk("b2b_cnt4", instret, 64'd14);
    chk("b2b_vld", 64'(valid_wb), 64'd0);

    // Reset while a load waits
    issue(5'd9, 1'b1, 3'b010, 32'h400, 32'h90);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_valid", 64'(valid_wb), 64'd0);
    chk("mr_we", 64'(rf_we), 64'd0);
    chk("mr_cnt", instret, 64'd0);
    chk("mr_allow", 64'(allow_in_wb), 64'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_valid", 64'(valid_wb), 64'd0);
    chk("late_cnt", instret, 64'd0);
    issue(5'd3, 1'b1, 3'b010, 32'h500, 32'h94);
    chk("post_rdy", 64'(ready_go_wb), 64'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0BADCAFE;
    #1;
    chk("post_wd", 64'(rf_wd), 64'h0BADCAFE);
    tick();
    dmem_rvalid = 1'b0;
    chk("post_cnt", instret, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
